// File: rtl/assoc_seq_search.sv
// Associative sequential search: scans NUM_CLASSES class hypervectors from an
// external synchronous-read memory, one per cycle, and reports the class whose
// AND-overlap with the latched query has the highest popcount (lowest index
// wins a tie).
module assoc_seq_search #(
  parameter int DIM         = 50,
  parameter int NUM_CLASSES = 26,
  parameter int IDX_W       = 5,
  parameter int CNT_W       = 6,
  parameter int MATCH_TH    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM-1:0]   query_hv,
  output logic [IDX_W-1:0] mem_addr,
  output logic             mem_rd_en,
  input  logic [DIM-1:0]   mem_rdata,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] best_idx,
  output logic [CNT_W-1:0] best_score,
  output logic             match_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(NUM_CLASSES - 1);

  state_e           state_q, state_d;
  logic [DIM-1:0]   query_q, query_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic             rd_en_q, rd_en_d;
  // Pipeline copies aligned with the cycle in which mem_rdata is valid.
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_score_q, best_score_d;
  logic             match_valid_q, match_valid_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] score;

  // Count of set bits, accumulated at full CNT_W width so DIM ones fit.
  function automatic logic [CNT_W-1:0] popcount(input logic [DIM-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DIM; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Overlap score of the class word returned this cycle.
  always_comb begin
    score = popcount(query_q & mem_rdata);
  end

  // Next-state, address sequencing and best-match tracking.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    query_d       = query_q;
    addr_d        = addr_q;
    rd_en_d       = 1'b0;
    idx_d         = addr_q;
    vld_d         = rd_en_q;
    best_idx_d    = best_idx_q;
    best_score_d  = best_score_q;
    match_valid_d = match_valid_q;
    done_d        = 1'b0;

    // Strictly greater keeps the earliest (lowest) index on a tie.
    if (vld_q && (score > best_score_q)) begin
      best_idx_d    = idx_q;
      best_score_d  = score;
      match_valid_d = (int'(score) >= MATCH_TH);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RUN;
          query_d       = query_hv;
          addr_d        = '0;
          rd_en_d       = 1'b1;
          best_idx_d    = '0;
          best_score_d  = '0;
          match_valid_d = (MATCH_TH <= 0);
        end
      end
      RUN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          addr_d  = addr_q + IDX_W'(1);
          rd_en_d = 1'b1;
        end
      end
      DRAIN: begin
        // The last class word arrives this cycle; results settle at its end.
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any search in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      // NOTE: the query register is reset as well, so a search abandoned by
      // reset leaves no stale vector behind.
      query_q       <= '0;
      addr_q        <= '0;
      rd_en_q       <= 1'b0;
      idx_q         <= '0;
      vld_q         <= 1'b0;
      best_idx_q    <= '0;
      best_score_q  <= '0;
      match_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      query_q       <= query_d;
      addr_q        <= addr_d;
      rd_en_q       <= rd_en_d;
      idx_q         <= idx_d;
      vld_q         <= vld_d;
      best_idx_q    <= best_idx_d;
      best_score_q  <= best_score_d;
      match_valid_q <= match_valid_d;
      done_q        <= done_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign best_idx    = best_idx_q;
  assign best_score  = best_score_q;
  assign match_valid = match_valid_q;

endmodule

// File: doc/assoc_seq_search.md
ASSOC_SEQ_SEARCH -- requirements
Module: assoc_seq_search

Interface
REQ-001 Parameter DIM, default 50: hypervector width in bits.
REQ-002 Parameter NUM_CLASSES, default 26: class hypervectors scanned per search.
REQ-003 Parameter IDX_W, default 5: class index width, at least ceil(log2(NUM_CLASSES)).
REQ-004 Parameter CNT_W, default 6: score width, at least ceil(log2(DIM+1)).
REQ-005 Parameter MATCH_TH, default 8: minimum score for a valid match.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  search request; sampled only in IDLE.
REQ-009 query_hv  input  DIM  query hypervector; captured on the accepted start.
REQ-010 mem_addr  output  IDX_W  class-memory read address.
REQ-011 mem_rd_en  output  1  class-memory read strobe.
REQ-012 mem_rdata  input  DIM  class hypervector; valid exactly one cycle after its mem_rd_en.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when results are final.
REQ-015 best_idx  output  IDX_W  index of the best-scoring class.
REQ-016 best_score  output  CNT_W  popcount(query AND best class).
REQ-017 match_valid  output  1  high when best_score >= MATCH_TH.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE, encoded in a registered state.
REQ-019 In IDLE with start=1, the block SHALL latch query_hv, clear best_score to 0, clear best_idx to 0, clear the address counter and enter RUN.
REQ-020 In RUN, the block SHALL assert mem_rd_en=1 with mem_addr=k for k=0..NUM_CLASSES-1 on consecutive cycles, one address per cycle with no gaps.
REQ-021 After issuing address NUM_CLASSES-1, RUN SHALL go to DRAIN for one cycle with mem_rd_en=0.
REQ-022 In every cycle that follows a cycle with mem_rd_en=1, the block SHALL compute score = popcount(latched query AND mem_rdata) at CNT_W bits with no truncation.
REQ-023 The block SHALL overwrite best_score and best_idx only when score > best_score (strictly greater), so that on a tie the lowest index is kept.
REQ-024 Index tracking SHALL use a one-cycle-delayed copy of mem_addr.
REQ-025 DRAIN SHALL go to DONE; DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-026 Latency: done SHALL be high in cycle NUM_CLASSES+2 after the start-accepting edge, which is cycle 28 with default parameters.
REQ-027 best_idx, best_score and match_valid SHALL be final when done is high.
REQ-028 best_idx, best_score and match_valid SHALL hold their values until the next accepted start.
REQ-029 match_valid SHALL be registered and updated together with best_score.
REQ-030 The block SHALL ignore start in RUN, DRAIN and DONE: no restart and no effect on the results.
REQ-031 A new start SHALL be accepted in the first IDLE cycle after DONE.
REQ-032 A change on query_hv after acceptance SHALL NOT affect the running search.
REQ-033 If every score is 0, the result SHALL be best_idx=0, best_score=0 and match_valid=0 (when MATCH_TH>0).
REQ-034 mem_rd_en SHALL be 0 in IDLE, DRAIN and DONE, and mem_addr SHALL be stable in those states.

Reset
REQ-035 While rst_n=0, regardless of state, the block SHALL immediately force: state=IDLE, busy=0, done=0, mem_rd_en=0, mem_addr=0, best_idx=0, best_score=0, match_valid=0, and the latched query to 0.
REQ-036 Reset asserted mid-search SHALL abandon the search, produce no done pulse, and require a new start after rst_n rises.
REQ-037 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-038 Single match: query=0x3FFFF (bits 0..17 set); class 7=0x3FFFF; all other classes have 4 or fewer overlapping bits -> done at cycle 28, best_idx=7, best_score=18, match_valid=1.
REQ-039 Tie: classes 3 and 12 each overlap the query in 10 bits and all others in fewer -> best_idx=3, best_score=10.
REQ-040 All-zero query -> best_idx=0, best_score=0, match_valid=0, done still at cycle 28.
REQ-041 Full overlap: query all ones and class 25 all ones -> best_idx=25, best_score=50 (no overflow).
REQ-042 Start pulsed in RUN and query_hv changed mid-search -> results match the originally captured query, exactly one done pulse, 26 mem_rd_en cycles.
REQ-043 rst_n dropped at RUN cycle 10 -> all outputs 0 immediately and no done; the next start then completes normally in 28 cycles.
